// File: rtl/gpc_pkg.sv
// Shared types and parameter checks for the bit-serial GPC accumulator.
package gpc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StOut
  } gpc_acc_state_t;

  // True when the operand/accumulator widths form a legal configuration.
  function automatic bit gpc_widths_ok(input int unsigned opw, input int unsigned accw);
    return (opw >= 2) && (accw >= opw) && ((accw % 2) == 0);
  endfunction

endpackage

// File: rtl/gpc_2_3__3.sv
// (2,3;3) generalized parallel counter: three weight-1 bits plus two weight-2 bits.
module gpc_2_3__3 (
  input  logic [2:0] i_c0,
  input  logic [1:0] i_c1,
  output logic [2:0] o_z
);

  always_comb begin
    o_z = {2'b00, i_c0[0]} + {2'b00, i_c0[1]} + {2'b00, i_c0[2]}
        + {1'b0, i_c1[0], 1'b0} + {1'b0, i_c1[1], 1'b0};
  end

endmodule

// File: rtl/gpc_serial_acc.sv
// Multi-operand accumulator that adds each operand two bits per cycle through one GPC.
module gpc_serial_acc
  import gpc_pkg::*;
#(
  parameter int unsigned OPW  = 16,
  parameter int unsigned ACCW = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_sum,
  output logic            out_ovf,
  output logic            busy
);

  localparam int unsigned StepW = (ACCW > 2) ? $clog2(ACCW / 2) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(ACCW / 2 - 1);

  if (!gpc_widths_ok(OPW, ACCW)) begin : g_bad_params
    $error("gpc_serial_acc: illegal OPW/ACCW combination");
  end

  gpc_acc_state_t r_state, w_state_nxt;
  logic [ACCW-1:0]  r_acc, w_acc_nxt;
  logic [ACCW-1:0]  r_op, w_op_nxt;
  logic             r_carry, w_carry_nxt;
  logic [StepW-1:0] r_step, w_step_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_last, w_last_nxt;
  logic [2:0]       w_z;

  gpc_2_3__3 u_gpc (
    .i_c0 ({r_carry, r_op[0], r_acc[0]}),
    .i_c1 ({r_op[1], r_acc[1]}),
    .o_z  (w_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_op    <= '0;
      r_carry <= 1'b0;
      r_step  <= '0;
      r_ovf   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_op    <= w_op_nxt;
      r_carry <= w_carry_nxt;
      r_step  <= w_step_nxt;
      r_ovf   <= w_ovf_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_op_nxt    = r_op;
    w_carry_nxt = r_carry;
    w_step_nxt  = r_step;
    w_ovf_nxt   = r_ovf;
    w_last_nxt  = r_last;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_op_nxt    = ACCW'(in_data);
          w_carry_nxt = 1'b0;
          w_step_nxt  = '0;
          w_last_nxt  = in_last;
          w_state_nxt = StAdd;
        end
      end
      StAdd: begin
        // Rotate the accumulator right; after ACCW/2 steps it is back in alignment.
        w_acc_nxt   = (r_acc >> 2) | (ACCW'({w_z[1], w_z[0]}) << (ACCW - 2));
        w_op_nxt    = r_op >> 2;
        w_carry_nxt = w_z[2];
        w_step_nxt  = r_step + StepW'(1);
        if (r_step == StepLast) begin
          w_ovf_nxt   = r_ovf | w_z[2];
          w_carry_nxt = 1'b0;
          w_step_nxt  = '0;
          w_state_nxt = r_last ? StOut : StIdle;
        end
      end
      StOut: begin
        if (out_ready) begin
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StOut);
    busy      = (r_state != StIdle);
    out_sum   = out_valid ? r_acc : '0;
    out_ovf   = out_valid & r_ovf;
  end

endmodule

// File: tb/tb_gpc_serial_acc.sv
// Directed bench for gpc_serial_acc with OPW=4, ACCW=8 (four ADD cycles per operand).
module tb_gpc_serial_acc;

  localparam int unsigned OPW  = 4;
  localparam int unsigned ACCW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [OPW-1:0]  in_data = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [ACCW-1:0] out_sum;
  logic            out_ovf;
  logic            busy;

  int total = 0;
  int bad   = 0;

  gpc_serial_acc #(.OPW(OPW), .ACCW(ACCW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             n;
    logic [OPW-1:0] val;
    logic [ACCW-1:0] exp_sum;
    logic           exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_out_sum"}, 32'(out_sum), 0);
    check({tag, "_out_ovf"}, 32'(out_ovf), 0);
  endtask

  // Offers an operand and returns 1ns after the accepting edge.
  task automatic accept_op(input logic [OPW-1:0] v, input logic last);
    int  n;
    bit  seen;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    n = 0;
    seen = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      if (in_ready) seen = 1;
      else n++;
    end
    if (!seen) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  task automatic send_op(input logic [OPW-1:0] v, input logic last);
    int low;
    accept_op(v, last);
    low = 0;
    repeat (4) begin
      @(negedge clk);
      if (!in_ready && !out_valid && busy) low++;
    end
    check("add_phase_cycles", 32'(low), 4);
    @(negedge clk);
    check("ready_after_add", 32'(in_ready), 32'(!last));
    check("valid_after_add", 32'(out_valid), 32'(last));
  endtask

  task automatic get_result(input logic [ACCW-1:0] es, input logic eo, input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", 32'(out_valid), 1);
    check("out_sum", 32'(out_sum), 32'(es));
    check("out_ovf", 32'(out_ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      in_data  = OPW'($urandom);
      in_last  = 1'b1;
      @(negedge clk);
      check("hold_stable", {out_valid, in_ready, out_ovf, 21'd0, out_sum},
            {1'b1, 1'b0, eo, 21'd0, es});
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_hs_ready", 32'(in_ready), 1);
    check("post_hs_valid", 32'(out_valid), 0);
    check("post_hs_sum", 32'(out_sum), 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{n: 1,  val: 4'd5,  exp_sum: 8'd5,   exp_ovf: 1'b0};
    vecs[1] = '{n: 3,  val: 4'd15, exp_sum: 8'd45,  exp_ovf: 1'b0};
    vecs[2] = '{n: 18, val: 4'd15, exp_sum: 8'd14,  exp_ovf: 1'b1};
    vecs[3] = '{n: 1,  val: 4'd3,  exp_sum: 8'd3,   exp_ovf: 1'b0};
    vecs[4] = '{n: 17, val: 4'd15, exp_sum: 8'd255, exp_ovf: 1'b0};
    vecs[5] = '{n: 4,  val: 4'd7,  exp_sum: 8'd28,  exp_ovf: 1'b0};
    vecs[6] = '{n: 2,  val: 4'd0,  exp_sum: 8'd0,   exp_ovf: 1'b0};
    vecs[7] = '{n: 35, val: 4'd15, exp_sum: 8'd13,  exp_ovf: 1'b1};

    #1;
    check_reset_outputs("reset");
    #21 rst_n = 1'b1;

    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].n; k++) send_op(vecs[v].val, (k == vecs[v].n - 1));
      get_result(vecs[v].exp_sum, vecs[v].exp_ovf, 0);
    end

    // Mixed operand values: 9 + 10 + 11 + 12 = 42.
    send_op(4'd9, 1'b0);
    send_op(4'd10, 1'b0);
    send_op(4'd11, 1'b0);
    send_op(4'd12, 1'b1);
    get_result(8'd42, 1'b0, 0);

    // Result held off for 10 cycles while junk is offered on the input.
    send_op(4'd13, 1'b0);
    send_op(4'd14, 1'b1);
    get_result(8'd27, 1'b0, 10);

    // Reset in the second ADD cycle discards the partial sum.
    send_op(4'd4, 1'b0);
    accept_op(4'd9, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_add_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_op(4'd6, 1'b1);
    get_result(8'd6, 1'b0, 0);

    // Reset while a result is pending with out_ready asserted.
    send_op(4'd2, 1'b1);
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("out_reset");
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Junk handshakes during ADD must be ignored.
    accept_op(4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = ~i[0];
      in_data  = 4'hF;
      in_last  = 1'b1;
      @(negedge clk);
      check("junk_ready_low", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    @(negedge clk);
    check("junk_back_idle", 32'(in_ready), 1);
    send_op(4'd0, 1'b1);
    get_result(8'd0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
